// File: rtl/stage2_seq_check_ctrl_pkg.sv
// Shared widths, initial counter value, FSM encodings and the seq classifier
// used by the stage-2 sequence check controller.
package stage2_seq_check_ctrl_pkg;

  localparam int SEQ_NUMBER_DATA_BITS    = 32;
  localparam int SEQ_NUMBER_DATA_INITIAL = 1;

  localparam logic [1:0] SEQ_ST_SYNC    = 2'd0;
  localparam logic [1:0] SEQ_ST_GAP_REQ = 2'd1;
  localparam logic [1:0] SEQ_ST_RECOVER = 2'd2;
  localparam logic [1:0] SEQ_ST_ERROR   = 2'd3;

  typedef enum logic [1:0] {
    SEQ_CLS_IN_ORDER = 2'd0,
    SEQ_CLS_AHEAD    = 2'd1,
    SEQ_CLS_STALE    = 2'd2
  } seq_cls_e;

  // Modular compare: zero difference is in order, a set MSB means the
  // message lies behind the expected seq, anything else is a gap.
  function automatic seq_cls_e seq_classify(input logic diff_zero, input logic diff_msb);
    if (diff_zero)     return SEQ_CLS_IN_ORDER;
    else if (diff_msb) return SEQ_CLS_STALE;
    else               return SEQ_CLS_AHEAD;
  endfunction

endpackage

// File: rtl/stage2_seq_check_ctrl_if.sv
// Header input, forward output and retransmit request bundle of the
// stage-2 sequence check controller.
interface stage2_seq_check_ctrl_if #(
  parameter int SEQ_W = 32
) ();

  logic             msg_valid;
  logic             msg_ready;
  logic [SEQ_W-1:0] msg_seq;
  logic             msg_sess_rst;

  logic             fwd_valid;
  logic [SEQ_W-1:0] fwd_seq;

  logic             gap_req_valid;
  logic             gap_req_ready;
  logic [SEQ_W-1:0] gap_req_start;
  logic [SEQ_W-1:0] gap_req_count;

  modport master (
    output msg_valid, msg_seq, msg_sess_rst, gap_req_ready,
    input  msg_ready, fwd_valid, fwd_seq, gap_req_valid, gap_req_start, gap_req_count
  );

  modport slave (
    input  msg_valid, msg_seq, msg_sess_rst, gap_req_ready,
    output msg_ready, fwd_valid, fwd_seq, gap_req_valid, gap_req_start, gap_req_count
  );

endinterface

// File: rtl/stage2_sat_counter.sv
// Statistic counter that sticks at all-ones instead of wrapping.
module stage2_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, hold once saturated.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/stage2_seq_check_ctrl.sv
// Stage-2 sequence check controller: forwards in-order headers, drops
// stale/duplicate ones and requests retransmission of gaps with retry.
//
//   state   | meaning
//   SYNC    | in sequence, forwarding; an ahead seq opens a gap request
//   GAP_REQ | retransmit request presented, input stalled
//   RECOVER | waiting for retransmitted seqs up to last, timer running
//   ERROR   | retries exhausted, everything but session reset dropped
module stage2_seq_check_ctrl
  import stage2_seq_check_ctrl_pkg::*;
#(
  parameter int SEQ_W     = SEQ_NUMBER_DATA_BITS,
  parameter int SEQ_INIT  = SEQ_NUMBER_DATA_INITIAL,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3,
  parameter int STAT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stage2_seq_check_ctrl_if.slave bus,
  input  logic [SEQ_W-1:0]      seq_number_data,
  output logic                  message_en,
  output logic                  seq_number_control,
  output logic                  seq_err,
  output logic [STAT_W-1:0]     dup_cnt,
  output logic [STAT_W-1:0]     drop_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  logic [1:0]       state;
  logic [SEQ_W-1:0] last_seq;
  logic [SEQ_W-1:0] gap_start;
  logic [SEQ_W-1:0] gap_count;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry;
  logic             fwd_valid_q;
  logic [SEQ_W-1:0] fwd_seq_q;

  logic [SEQ_W-1:0] diff;
  seq_cls_e         cls;
  logic             acc;
  logic             live;
  logic             sess_acc;
  logic             data_acc;
  logic             fwd_hit;
  logic             dup_inc;
  logic             drop_inc;

  assign bus.msg_ready     = (state != SEQ_ST_GAP_REQ);
  assign bus.gap_req_valid = (state == SEQ_ST_GAP_REQ);
  assign bus.gap_req_start = gap_start;
  assign bus.gap_req_count = gap_count;
  assign bus.fwd_valid     = fwd_valid_q;
  assign bus.fwd_seq       = fwd_seq_q;
  assign seq_err           = (state == SEQ_ST_ERROR);

  // Classify the offered header and derive counter control and stat strobes.
  // Gating acc with rst_n keeps the external counter quiet during reset.
  always_comb begin
    diff     = bus.msg_seq - seq_number_data;
    cls      = seq_classify(diff == '0, diff[SEQ_W-1]);
    acc      = bus.msg_valid & bus.msg_ready & rst_n;
    live     = (state == SEQ_ST_SYNC) || (state == SEQ_ST_RECOVER);
    sess_acc = acc & bus.msg_sess_rst;
    data_acc = acc & ~bus.msg_sess_rst;
    fwd_hit  = data_acc & live & (cls == SEQ_CLS_IN_ORDER);
    dup_inc  = data_acc & live & (cls == SEQ_CLS_STALE);
    drop_inc = data_acc & ((live & (cls == SEQ_CLS_AHEAD)) | (state == SEQ_ST_ERROR));
    message_en         = fwd_hit | sess_acc;
    seq_number_control = fwd_hit;
  end

  // Registered forward path: one cycle after an in-order accept, no backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_seq_q   <= '0;
    end else begin
      fwd_valid_q <= fwd_hit;
      if (fwd_hit)
        fwd_seq_q <= bus.msg_seq;
    end
  end

  // Gap handling FSM with retry and recovery timer; session reset overrides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SEQ_ST_SYNC;
      last_seq  <= '0;
      gap_start <= '0;
      gap_count <= '0;
      timer     <= '0;
      retry     <= '0;
    end else if (sess_acc) begin
      state <= SEQ_ST_SYNC;
      retry <= '0;
      timer <= '0;
    end else begin
      case (state)
        SEQ_ST_SYNC: begin
          if (data_acc && (cls == SEQ_CLS_AHEAD)) begin
            last_seq  <= bus.msg_seq;
            gap_start <= seq_number_data;
            gap_count <= diff + SEQ_W'(1);
            retry     <= RTY_W'(1);
            state     <= SEQ_ST_GAP_REQ;
          end
        end
        SEQ_ST_GAP_REQ: begin
          if (bus.gap_req_ready) begin
            timer <= TMR_W'(TIMEOUT);
            state <= SEQ_ST_RECOVER;
          end
        end
        SEQ_ST_RECOVER: begin
          // An in-order accept on the expiry cycle still counts as progress.
          if (fwd_hit) begin
            timer <= TMR_W'(TIMEOUT);
            if (bus.msg_seq == last_seq) begin
              retry <= '0;
              state <= SEQ_ST_SYNC;
            end
          end else if (timer == '0) begin
            if (retry < RTY_W'(MAX_RETRY)) begin
              retry     <= retry + RTY_W'(1);
              gap_start <= seq_number_data;
              gap_count <= last_seq - seq_number_data + SEQ_W'(1);
              state     <= SEQ_ST_GAP_REQ;
            end else begin
              state <= SEQ_ST_ERROR;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        SEQ_ST_ERROR: begin
          state <= SEQ_ST_ERROR;
        end
        default: begin
          state <= SEQ_ST_SYNC;
        end
      endcase
    end
  end

  stage2_sat_counter #(.W(STAT_W)) u_dup_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dup_inc),
    .cnt   (dup_cnt)
  );

  stage2_sat_counter #(.W(STAT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .cnt   (drop_cnt)
  );

endmodule

// File: tb/tb_stage2_seq_check_ctrl.sv
// Directed bench for stage2_seq_check_ctrl with a behavioural expected-seq
// counter standing in for stage2_seq_number_module.
module tb_stage2_seq_check_ctrl;
  import stage2_seq_check_ctrl_pkg::*;

  localparam int SEQ_W     = 32;
  localparam int STAT_W    = 16;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 3;
  localparam int SEQ_INIT  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SEQ_W-1:0]  seq_number_data;
  logic              message_en;
  logic              seq_number_control;
  logic              seq_err;
  logic [STAT_W-1:0] dup_cnt;
  logic [STAT_W-1:0] drop_cnt;
  logic              cnt_load;
  logic [SEQ_W-1:0]  cnt_load_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stage2_seq_check_ctrl_if #(.SEQ_W(SEQ_W)) bus ();

  stage2_seq_check_ctrl #(
    .SEQ_W     (SEQ_W),
    .SEQ_INIT  (SEQ_INIT),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY),
    .STAT_W    (STAT_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus),
    .seq_number_data    (seq_number_data),
    .message_en         (message_en),
    .seq_number_control (seq_number_control),
    .seq_err            (seq_err),
    .dup_cnt            (dup_cnt),
    .drop_cnt           (drop_cnt)
  );

  // Expected-seq counter model; cnt_load lets the bench preset it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      seq_number_data <= SEQ_W'(SEQ_INIT);
    else if (cnt_load)
      seq_number_data <= cnt_load_val;
    else if (message_en)
      seq_number_data <= seq_number_control ? seq_number_data + SEQ_W'(1) : SEQ_W'(SEQ_INIT);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input logic [SEQ_W-1:0] v);
    cnt_load     = 1'b1;
    cnt_load_val = v;
    tick();
    cnt_load     = 1'b0;
  endtask

  task automatic send_fwd(input string tag, input logic [SEQ_W-1:0] s);
    bus.msg_valid = 1'b1;
    bus.msg_seq   = s;
    #1;
    check_val({tag, "_en_ctl"}, 64'({message_en, seq_number_control}), 64'(2'b11));
    tick();
    bus.msg_valid = 1'b0;
    check_val({tag, "_fwd_valid"}, 64'(bus.fwd_valid), 64'(1));
    check_val({tag, "_fwd_seq"}, 64'(bus.fwd_seq), 64'(s));
  endtask

  task automatic send_plain(input logic [SEQ_W-1:0] s);
    bus.msg_valid = 1'b1;
    bus.msg_seq   = s;
    #1;
    check_val("drop_en", 64'(message_en), 64'(0));
    tick();
    bus.msg_valid = 1'b0;
    check_val("drop_no_fwd", 64'(bus.fwd_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.msg_valid    = 1'b0;
    bus.msg_seq      = '0;
    bus.msg_sess_rst = 1'b0;
    bus.gap_req_ready = 1'b0;
    cnt_load         = 1'b0;
    cnt_load_val     = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // reset state
    check_val("rst_ready", 64'(bus.msg_ready), 64'(1));
    check_val("rst_fwd_valid", 64'(bus.fwd_valid), 64'(0));
    check_val("rst_gap_valid", 64'(bus.gap_req_valid), 64'(0));
    check_val("rst_seq_err", 64'(seq_err), 64'(0));
    check_val("rst_stats", 64'({dup_cnt, drop_cnt}), 64'(0));
    check_val("rst_en", 64'(message_en), 64'(0));

    // 1: in-order back-to-back
    send_fwd("t1_s1", 32'd1);
    send_fwd("t1_s2", 32'd2);
    send_fwd("t1_s3", 32'd3);
    check_val("t1_counter", 64'(seq_number_data), 64'(4));
    check_val("t1_no_gap", 64'(bus.gap_req_valid), 64'(0));
    send_fwd("t1_s4", 32'd4);

    // 2: gap from 5 to 9, recover
    send_plain(32'd9);
    check_val("t2_drop", 64'(drop_cnt), 64'(1));
    check_val("t2_gap_valid", 64'(bus.gap_req_valid), 64'(1));
    check_val("t2_gap_start", 64'(bus.gap_req_start), 64'(5));
    check_val("t2_gap_count", 64'(bus.gap_req_count), 64'(5));
    repeat (3) begin
      tick();
      check_val("t2_hold_valid", 64'(bus.gap_req_valid), 64'(1));
      check_val("t2_hold_ready", 64'(bus.msg_ready), 64'(0));
      check_val("t2_hold_start", 64'(bus.gap_req_start), 64'(5));
    end
    bus.gap_req_ready = 1'b1;
    tick();
    bus.gap_req_ready = 1'b0;
    check_val("t2_rec_ready", 64'(bus.msg_ready), 64'(1));
    check_val("t2_rec_gap_valid", 64'(bus.gap_req_valid), 64'(0));
    for (int s = 5; s <= 9; s++) send_fwd("t2_rec", 32'(s));
    check_val("t2_counter", 64'(seq_number_data), 64'(10));
    repeat (12) tick();
    check_val("t2_sync_no_rereq", 64'(bus.gap_req_valid), 64'(0));

    // 3: stale seq while expecting 5
    load_cnt(32'd5);
    send_plain(32'd3);
    check_val("t3_dup", 64'(dup_cnt), 64'(1));
    check_val("t3_drop_same", 64'(drop_cnt), 64'(1));
    check_val("t3_counter", 64'(seq_number_data), 64'(5));
    send_fwd("t3_sync", 32'd5);

    // 4: timeouts, retries, error, session reset
    send_plain(32'd10);
    check_val("t4_drop", 64'(drop_cnt), 64'(2));
    check_val("t4_gap_start", 64'(bus.gap_req_start), 64'(6));
    check_val("t4_gap_count", 64'(bus.gap_req_count), 64'(5));
    for (int r = 0; r < 3; r++) begin
      bus.gap_req_ready = 1'b1;
      tick();
      bus.gap_req_ready = 1'b0;
      repeat (8) tick();
      check_val("t4_pre_expiry", 64'(bus.gap_req_valid), 64'(0));
      tick();
      if (r < 2) begin
        check_val("t4_rereq_valid", 64'(bus.gap_req_valid), 64'(1));
        check_val("t4_rereq_start", 64'(bus.gap_req_start), 64'(6));
        check_val("t4_rereq_count", 64'(bus.gap_req_count), 64'(5));
      end else begin
        check_val("t4_seq_err", 64'(seq_err), 64'(1));
        check_val("t4_err_gap_valid", 64'(bus.gap_req_valid), 64'(0));
        check_val("t4_err_ready", 64'(bus.msg_ready), 64'(1));
      end
    end
    send_plain(32'd6);
    check_val("t4_err_drop", 64'(drop_cnt), 64'(3));
    check_val("t4_err_counter", 64'(seq_number_data), 64'(6));
    bus.msg_valid    = 1'b1;
    bus.msg_sess_rst = 1'b1;
    bus.msg_seq      = 32'd123;
    #1;
    check_val("t4_sess_en_ctl", 64'({message_en, seq_number_control}), 64'(2'b10));
    tick();
    bus.msg_valid    = 1'b0;
    bus.msg_sess_rst = 1'b0;
    check_val("t4_sess_seq_err", 64'(seq_err), 64'(0));
    check_val("t4_sess_counter", 64'(seq_number_data), 64'(SEQ_INIT));
    check_val("t4_sess_no_fwd", 64'(bus.fwd_valid), 64'(0));
    send_fwd("t4_after_sess", 32'd1);

    // 5: wrap-around
    load_cnt(32'hFFFF_FFFF);
    send_fwd("t5_max", 32'hFFFF_FFFF);
    send_fwd("t5_zero", 32'd0);
    check_val("t5_counter", 64'(seq_number_data), 64'(1));
    send_plain(32'hFFFF_FFFE);
    check_val("t5_stale_dup", 64'(dup_cnt), 64'(2));
    check_val("t5_stale_no_gap", 64'(bus.gap_req_valid), 64'(0));

    // 6: reset during request, then in-order accept on the expiry cycle
    send_plain(32'd4);
    check_val("t6_gap_valid", 64'(bus.gap_req_valid), 64'(1));
    check_val("t6_gap_count", 64'(bus.gap_req_count), 64'(4));
    rst_n = 1'b0;
    tick();
    check_val("t6_rst_gap_valid", 64'(bus.gap_req_valid), 64'(0));
    check_val("t6_rst_stats", 64'({dup_cnt, drop_cnt}), 64'(0));
    check_val("t6_rst_ready", 64'(bus.msg_ready), 64'(1));
    rst_n = 1'b1;
    send_fwd("t6_sync", 32'd1);
    send_plain(32'd5);
    check_val("t6_gap2_start", 64'(bus.gap_req_start), 64'(2));
    check_val("t6_gap2_count", 64'(bus.gap_req_count), 64'(4));
    bus.gap_req_ready = 1'b1;
    tick();
    bus.gap_req_ready = 1'b0;
    repeat (8) tick();
    send_fwd("t6_expiry_fwd", 32'd2);
    check_val("t6_no_rereq", 64'(bus.gap_req_valid), 64'(0));
    tick();
    check_val("t6_no_rereq_late", 64'(bus.gap_req_valid), 64'(0));
    check_val("t6_ready", 64'(bus.msg_ready), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
